// File: rtl/riscv_lsu.sv
// Load/store unit: one request at a time, byte enables + lane replication, sign/zero-extended loads.
// Build option LSU_MISALIGN_TRAP_EN: report misaligned accesses as errors instead of force-aligning them.
module riscv_lsu #(
  parameter int ADDR_W      = 12,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk_150_mhz,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [4:0]        rsp_rd,
  output logic              rsp_wb,
  output logic [1:0]        rsp_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-3:0] waddr_q;
  logic [1:0]        alo_q;
  logic [2:0]        f3_q;
  logic [31:0]       wdata_q;
  logic [4:0]        rd_q;
  logic              we_q;
  logic [3:0]        cnt_q;
  logic [1:0]        err_q;
  logic [31:0]       data_q;

  logic       accept;
  logic       illegal_c, oor_c, is_half, is_word;
  logic [1:0] err_c, alo_c;
  logic [7:0] byte_c;
  logic [15:0] half_c;
  logic [31:0] ext_c;

  assign accept  = req_valid & req_ready;
  assign is_half = (req_funct3[1:0] == 2'b01);
  assign is_word = (req_funct3[1:0] == 2'b10);
  assign illegal_c = req_we ? (req_funct3 >= 3'b011)
                            : (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111);
  assign oor_c = |req_addr[31:ADDR_W];

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_c;
  assign mis_c = (is_half & req_addr[0]) | (is_word & (req_addr[1:0] != 2'b00));
  assign err_c = illegal_c ? 2'b11 : mis_c ? 2'b01 : oor_c ? 2'b10 : 2'b00;
  assign alo_c = req_addr[1:0];
`else
  // Misalignment is silently dropped by clearing the offending low address bits.
  assign err_c = illegal_c ? 2'b11 : oor_c ? 2'b10 : 2'b00;
  assign alo_c = is_word ? 2'b00 : is_half ? {req_addr[1], 1'b0} : req_addr[1:0];
`endif

  always_comb begin
    byte_c = mem_rdata[7:0];
    case (alo_q)
      2'd1:    byte_c = mem_rdata[15:8];
      2'd2:    byte_c = mem_rdata[23:16];
      2'd3:    byte_c = mem_rdata[31:24];
      default: byte_c = mem_rdata[7:0];
    endcase
    half_c = alo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ext_c = {{24{byte_c[7]}}, byte_c};
      3'b001:  ext_c = {{16{half_c[15]}}, half_c};
      3'b010:  ext_c = mem_rdata;
      3'b100:  ext_c = {24'b0, byte_c};
      3'b101:  ext_c = {16'b0, half_c};
      default: ext_c = 32'b0;
    endcase
  end

  always_ff @(posedge clk_150_mhz) begin
    if (rst) begin
      state_q <= IDLE;
      waddr_q <= '0;
      alo_q   <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        waddr_q <= req_addr[ADDR_W-1:2];
        alo_q   <= alo_c;
        f3_q    <= req_funct3;
        wdata_q <= req_wdata;
        rd_q    <= req_rd;
        we_q    <= req_we;
        err_q   <= err_c;
        data_q  <= '0;
      end
      if (state_q == ACCESS && !we_q) cnt_q <= 4'(MEM_LATENCY);
      if (state_q == WAIT) begin
        cnt_q <= cnt_q - 4'd1;
        if (cnt_q == 4'd1) data_q <= ext_c;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (err_c != 2'b00) ? RESP : ACCESS;
      ACCESS:  state_d = we_q ? RESP : WAIT;
      WAIT:    if (cnt_q == 4'd1) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_rd    = '0;
    rsp_wb    = 1'b0;
    rsp_err   = '0;
    case (state_q)
      ACCESS: begin
        mem_addr = waddr_q;
        if (we_q) begin
          mem_we = 1'b1;
          case (f3_q[1:0])
            2'b00: begin
              mem_wdata = {4{wdata_q[7:0]}};
              mem_be    = 4'b0001 << alo_q;
            end
            2'b01: begin
              mem_wdata = {2{wdata_q[15:0]}};
              mem_be    = alo_q[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
              mem_wdata = wdata_q;
              mem_be    = 4'b1111;
            end
          endcase
        end else begin
          mem_re = 1'b1;
          mem_be = 4'b1111;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = data_q;
        rsp_rd    = rd_q;
        rsp_err   = err_q;
        rsp_wb    = !we_q && (err_q == 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Randomized bench for riscv_lsu against a byte-addressed reference memory model.
module tb_riscv_lsu;
  localparam int AW  = 12;
  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, req_valid, req_ready, req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr, req_wdata;
  logic [4:0]    req_rd;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [3:0]    mem_be;
  logic          mem_we, mem_re;
  logic          rsp_valid, rsp_ready, rsp_wb;
  logic [31:0]   rsp_data;
  logic [4:0]    rsp_rd;
  logic [1:0]    rsp_err;

  riscv_lsu #(.ADDR_W(AW), .MEM_LATENCY(LAT)) dut (
    .clk_150_mhz(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_wb(rsp_wb), .rsp_err(rsp_err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  // Memory as seen by the DUT: word array with byte-enable writes and a fixed read delay.
  logic        preload;
  logic [31:0] bus_mem [0:1023];
  logic [LAT:1] pv;
  logic [AW-3:0] pa [1:LAT];
  logic [31:0] junk;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) bus_mem[i] <= init_word(i);
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) bus_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    junk <= $urandom;
    if (preload) pv <= '0;
    else begin
      pv[1] <= mem_re;
      pa[1] <= mem_addr;
      for (int k = 2; k <= LAT; k++) begin
        pv[k] <= pv[k-1];
        pa[k] <= pa[k-1];
      end
    end
  end

  assign mem_rdata = pv[LAT] ? bus_mem[pa[LAT]] : junk;

  // Reference: plain byte array updated by completed stores.
  logic [7:0] ref_mem [0:4095];

  logic [31:0] last_wd;
  logic [3:0]  last_be;
  logic [AW-3:0] last_maddr;

  task automatic drive_junk();
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_rd     = 5'($urandom);
  endtask

  // Must be called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [4:0] rd, input int stall,
                      output logic [31:0] gd, output logic [1:0] ge);
    logic        ill, oor;
    logic [1:0]  e;
    logic [31:0] ea, xd, xwd;
    logic [3:0]  xbe;
    logic [7:0]  b0, b1, b2, b3;
    int lat, c, nre, nwe, sz;
    ill = we ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    oor = (addr >> AW) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
    e = ill ? 2'd3 : (((f3[1:0] == 2'd1) && addr[0]) || ((f3[1:0] == 2'd2) && addr[1:0] != 0)) ? 2'd1
        : oor ? 2'd2 : 2'd0;
`else
    e = ill ? 2'd3 : oor ? 2'd2 : 2'd0;
`endif
    ea = addr;
    if (f3[1:0] == 2'd1) ea[0] = 1'b0;
    else if (f3[1:0] == 2'd2) ea[1:0] = 2'b00;
    b0 = ref_mem[12'(ea)];
    b1 = ref_mem[12'(ea + 1)];
    b2 = ref_mem[12'(ea + 2)];
    b3 = ref_mem[12'(ea + 3)];
    xd = 32'd0;
    if (e == 0 && !we) begin
      case (f3)
        3'd0: xd = {{24{b0[7]}}, b0};
        3'd4: xd = {24'd0, b0};
        3'd1: xd = {{16{b1[7]}}, b1, b0};
        3'd5: xd = {16'd0, b1, b0};
        default: xd = {b3, b2, b1, b0};
      endcase
    end
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    xbe = 4'd0;
    xwd = 32'd0;
    for (int k = 0; k < sz; k++) xbe[(ea[1:0] + k) % 4] = 1'b1;
    for (int k = 0; k < 4; k++) xwd[8*k +: 8] = wd[8*(k % sz) +: 8];
    lat = (e != 0) ? 1 : we ? 2 : 2 + LAT;

    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0;
    drive_junk();
    c = 1; nre = 0; nwe = 0;
    while (!rsp_valid && c <= 20) begin
      chk("req_ready_busy", req_ready, 0);
      if (mem_we) begin
        nwe++;
        last_wd = mem_wdata; last_be = mem_be; last_maddr = mem_addr;
        chk("st_maddr", mem_addr, ea[AW-1:2]);
        chk("st_be", mem_be, xbe);
        chk("st_wdata", mem_wdata, xwd);
      end
      if (mem_re) begin
        nre++;
        last_maddr = mem_addr;
        chk("ld_maddr", mem_addr, ea[AW-1:2]);
        chk("ld_be", mem_be, 4'hF);
      end
      @(negedge clk);
      c++;
    end
    chk("rsp_latency", c, lat);
    chk("n_mem_we", nwe, (e == 0 && we) ? 1 : 0);
    chk("n_mem_re", nre, (e == 0 && !we) ? 1 : 0);
    gd = rsp_data;
    ge = rsp_err;
    chk("rsp_err", rsp_err, e);
    chk("rsp_wb", rsp_wb, (e == 0 && !we) ? 1 : 0);
    chk("rsp_data", rsp_data, xd);
    chk("rsp_rd", rsp_rd, rd);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_ready", req_ready, 0);
      chk("stall_data", rsp_data, xd);
      chk("stall_err", rsp_err, e);
      chk("stall_strobe", {mem_we, mem_re}, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_hs_valid", rsp_valid, 0);
    if (e == 0 && we)
      for (int k = 0; k < sz; k++) ref_mem[12'(ea + k)] = wd[8*k +: 8];
  endtask

  logic [31:0] gd;
  logic [1:0]  ge;

  initial begin
    for (int i = 0; i < 1024; i++)
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = init_word(i) >> (8*b);
    rst = 1'b1; preload = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    drive_junk();
    repeat (3) @(negedge clk);
    rst = 1'b0; preload = 1'b0;

    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mem_strb", {mem_we, mem_re, mem_be}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rsp", {rsp_data, rsp_rd, rsp_wb, rsp_err}, 0);

    xact(1'b1, 3'd2, 32'h010, 32'hDEADBEEF, 5'd1, 0, gd, ge);
    chk("sw_be", last_be, 4'hF);
    chk("sw_maddr", last_maddr, 10'h004);
    chk("sw_err", ge, 0);
    xact(1'b0, 3'd0, 32'h013, 32'h0, 5'd7, 0, gd, ge);
    chk("lb_data", gd, 32'hFFFFFFDE);
    xact(1'b0, 3'd4, 32'h013, 32'h0, 5'd8, 1, gd, ge);
    chk("lbu_data", gd, 32'h000000DE);
    xact(1'b0, 3'd1, 32'h012, 32'h0, 5'd9, 0, gd, ge);
    chk("lh_data", gd, 32'hFFFFDEAD);
    xact(1'b1, 3'd0, 32'h011, 32'h000000A5, 5'd2, 0, gd, ge);
    chk("sb_wdata", last_wd, 32'hA5A5A5A5);
    chk("sb_be", last_be, 4'b0010);
    xact(1'b0, 3'd2, 32'h012, 32'h0, 5'd10, 0, gd, ge);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_err", ge, 2'd1);
    chk("lw_mis_data", gd, 0);
`else
    chk("lw_mis_err", ge, 2'd0);
    chk("lw_mis_data", gd, 32'hDEADA5EF);
`endif
    xact(1'b0, 3'd2, 32'h00001000, 32'h0, 5'd11, 0, gd, ge);
    chk("lw_oor_err", ge, 2'd2);
    xact(1'b0, 3'd3, 32'h010, 32'h0, 5'd12, 0, gd, ge);
    chk("ld_ill_err", ge, 2'd3);
    xact(1'b1, 3'd3, 32'h00002001, 32'h0, 5'd13, 0, gd, ge);
    chk("st_ill_prio", ge, 2'd3);
    xact(1'b0, 3'd2, 32'h010, 32'h0, 5'd14, 5, gd, ge);
    chk("lw_stall_data", gd, 32'hDEADA5EF);

    // Reset while the load is waiting on memory.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h020; req_rd = 5'd3;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_req_ready", req_ready, 1);
    chk("rstw_rsp_valid", rsp_valid, 0);
    chk("rstw_mem_re", mem_re, 0);
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      chk("rstw_no_rsp", rsp_valid, 0);
    end

    for (int t = 0; t < 250; t++) begin
      logic we;
      logic [2:0] f3;
      logic [31:0] a;
      int r;
      we = ($urandom_range(0, 2) == 0);
      r  = $urandom_range(0, 99);
      if (r < 85) begin
        f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4));
        if (!we && f3 == 3'd3) f3 = 3'd4;
        if (!we && f3 == 3'd4 && $urandom_range(0, 1) == 1) f3 = 3'd5;
      end else f3 = 3'($urandom);
      r = $urandom_range(0, 99);
      if (r < 90) a = $urandom_range(0, 63);
      else if (r < 95) a = $urandom_range(0, 4095);
      else a = $urandom;
      xact(we, f3, a, $urandom, 5'($urandom), $urandom_range(0, 3), gd, ge);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
